sram_rr_arbiter: RTL and testbench

- Two-port round-robin arbiter and burst sequencer in front of the single-port 32x1024 SoC data SRAM (CEN/WEN active-low, 1-cycle read latency).
- Shares the SRAM between requester 0 (core load/store path) and requester 1 (FP post-processing accelerator).
- Read bursts of up to 8 words, so the accelerator can fetch one 8-word detection record (score, 4 box coordinates, class, flag, index) back-to-back.

---
 rtl/sram_rr_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sram_rr_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter and read-burst sequencer sharing one single-port SRAM
// between two requesters. The beat is issued combinationally; read valid is registered.
module sram_rr_arbiter #(
    parameter int AW   = 10,
    parameter int DW   = 32,
    parameter int LENW = 4
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            req0,
    input  logic            req1,
    input  logic            we0,
    input  logic            we1,
    input  logic [AW-1:0]   addr0,
    input  logic [AW-1:0]   addr1,
    input  logic [LENW-1:0] len0,
    input  logic [LENW-1:0] len1,
    input  logic [DW-1:0]   wdata0,
    input  logic [DW-1:0]   wdata1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [DW-1:0]   rdata0,
    output logic [DW-1:0]   rdata1,
    output logic            busy,
    output logic            CEN,
    output logic            WEN,
    output logic [AW-1:0]   A,
    output logic [DW-1:0]   D,
    input  logic [DW-1:0]   Q
);

    typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t          state_r;
    logic            owner_r;
    logic            prio_r;
    logic [LENW-1:0] cnt_r;
    logic [AW-1:0]   nxt_addr_r;
    logic            rv0_r;
    logic            rv1_r;

    logic            win_s;
    logic            we_w_s;
    logic [AW-1:0]   addr_w_s;
    logic [LENW-1:0] len_w_s;
    logic [DW-1:0]   wdata_w_s;
    logic [LENW-1:0] eff_len_s;
    logic            issue_s;
    logic            issue_rd_s;
    logic            who_s;
    logic [AW-1:0]   beat_addr_s;

    // Winner selection, length clamping and beat source for the current cycle.
    always_comb begin
        win_s       = 1'b0;
        issue_s     = 1'b0;
        issue_rd_s  = 1'b0;
        who_s       = 1'b0;
        beat_addr_s = '0;
        if (req0 && req1) begin
            win_s = prio_r;
        end else begin
            win_s = req1;
        end
        we_w_s    = win_s ? we1    : we0;
        addr_w_s  = win_s ? addr1  : addr0;
        len_w_s   = win_s ? len1   : len0;
        wdata_w_s = win_s ? wdata1 : wdata0;
        if (len_w_s == LENW'(4'd0)) begin
            eff_len_s = LENW'(4'd1);
        end else if (len_w_s > LENW'(4'd8)) begin
            eff_len_s = LENW'(4'd8);
        end else begin
            eff_len_s = len_w_s;
        end
        case (state_r)
            IDLE: begin
                issue_s     = req0 | req1;
                issue_rd_s  = (req0 | req1) & ~we_w_s;
                who_s       = win_s;
                beat_addr_s = addr_w_s;
            end
            BURST: begin
                issue_s     = owner_r ? req1 : req0;
                issue_rd_s  = owner_r ? req1 : req0;
                who_s       = owner_r;
                beat_addr_s = nxt_addr_r;
            end
            default: begin
                issue_s     = 1'b0;
                issue_rd_s  = 1'b0;
                who_s       = 1'b0;
                beat_addr_s = '0;
            end
        endcase
    end

    // SRAM strobes are held inactive while RSTN is low so the SRAM can preload.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        CEN  = 1'b1;
        WEN  = 1'b1;
        A    = '0;
        D    = '0;
        if (RSTN && issue_s) begin
            gnt0 = ~who_s;
            gnt1 = who_s;
            CEN  = 1'b0;
            WEN  = issue_rd_s;
            A    = beat_addr_s;
            D    = (state_r == IDLE) ? wdata_w_s : '0;
        end else begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Burst FSM, round-robin priority and read-valid pipeline.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r    <= IDLE;
            owner_r    <= 1'b0;
            prio_r     <= 1'b0;
            cnt_r      <= '0;
            nxt_addr_r <= '0;
            rv0_r      <= 1'b0;
            rv1_r      <= 1'b0;
        end else begin
            rv0_r <= issue_s & issue_rd_s & ~who_s;
            rv1_r <= issue_s & issue_rd_s & who_s;
            case (state_r)
                IDLE: begin
                    if (issue_s) begin
                        if (!we_w_s && (eff_len_s > LENW'(4'd1))) begin
                            state_r    <= BURST;
                            owner_r    <= win_s;
                            cnt_r      <= eff_len_s - LENW'(4'd1);
                            nxt_addr_r <= addr_w_s + AW'(1'b1);
                        end else begin
                            prio_r <= ~win_s;
                        end
                    end
                end
                BURST: begin
                    if (issue_s) begin
                        nxt_addr_r <= nxt_addr_r + AW'(1'b1);
                        cnt_r      <= cnt_r - LENW'(4'd1);
                        if (cnt_r == LENW'(4'd1)) begin
                            state_r <= IDLE;
                            prio_r  <= ~owner_r;
                        end
                    end else begin
                        // Owner dropped its request: abandon the rest of the burst.
                        state_r <= IDLE;
                        prio_r  <= ~owner_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign rvalid0 = rv0_r;
    assign rvalid1 = rv1_r;
    assign rdata0  = Q;
    assign rdata1  = Q;
    assign busy    = (state_r == BURST);

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural 32x1024 SRAM
// (1-cycle read latency) attached to CEN/WEN/A/D/Q.
module tb_sram_rr_arbiter;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        req0, req1, we0, we1;
    logic [9:0]  addr0, addr1;
    logic [3:0]  len0, len1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy, CEN, WEN;
    logic [31:0] rdata0, rdata1, D;
    logic [31:0] Q = 32'h0;
    logic [9:0]  A;
    logic [31:0] mem [0:1023];
    int          checks = 0;
    int          errors = 0;
    int          rv_cnt;

    always #5 CLK = ~CLK;

    sram_rr_arbiter #(.AW(10), .DW(32), .LENW(4)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(Q)
    );

    always @(posedge CLK) begin
        if (!CEN) begin
            if (!WEN) mem[A] <= D;
            else      Q <= mem[A];
        end
    end

    function automatic logic [31:0] pat(input int a);
        return 32'h5000_0000 + 32'(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(negedge CLK);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = pat(i);
        mem[1] = 32'h3fe00000;
        mem[8] = 32'h1;
        mem[9] = 32'h3fea3d70;
        RSTN = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 10'd0; addr1 = 10'd0; len0 = 4'd1; len1 = 4'd1;
        wdata0 = 32'h0; wdata1 = 32'h0;
        #1;
        chk("rst_cen", CEN, 1'b1);
        chk("rst_wen", WEN, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rv", {rvalid0, rvalid1}, 2'b00);
        cyc(); cyc();
        RSTN = 1'b1;

        // Single read by requester 0
        cyc(); req0 = 1'b1; addr0 = 10'd1; len0 = 4'd1; #1;
        chk("t1_gnt", {gnt0, gnt1}, 2'b10);
        chk("t1_cen", CEN, 1'b0);
        chk("t1_wen", WEN, 1'b1);
        chk("t1_a", A, 10'd1);
        // 8-beat burst by requester 1
        cyc(); req0 = 1'b0; req1 = 1'b1; addr1 = 10'd8; len1 = 4'd8; #1;
        chk("t1_rv0", {rvalid0, rvalid1}, 2'b10);
        chk("t1_rdata0", rdata0, 32'h3fe00000);
        chk("t2_gnt_0", {gnt0, gnt1}, 2'b01);
        chk("t2_a_0", A, 10'd8);
        chk("t2_busy_0", busy, 1'b0);
        for (int k = 1; k < 8; k++) begin
            cyc(); #1;
            chk("t2_gnt", {gnt0, gnt1}, 2'b01);
            chk("t2_a", A, 10'(8 + k));
            chk("t2_busy", busy, 1'b1);
            chk("t2_rv", rvalid1, 1'b1);
            chk("t2_rdata", rdata1, (k == 1) ? 32'h1 : (k == 2) ? 32'h3fea3d70 : pat(7 + k));
        end
        cyc(); req1 = 1'b0; #1;
        chk("t2_rv_last", rvalid1, 1'b1);
        chk("t2_rdata_last", rdata1, pat(15));
        chk("t2_busy_end", busy, 1'b0);
        chk("t2_cen_end", CEN, 1'b1);

        // Conflict: write by 0 wins (prio=0), then read by 1 sees the new data
        cyc();
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'd200; wdata0 = 32'hDEADBEEF;
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'd200; len1 = 4'd1; #1;
        chk("t3_gnt_w", {gnt0, gnt1}, 2'b10);
        chk("t3_wen", WEN, 1'b0);
        chk("t3_a", A, 10'd200);
        chk("t3_d", D, 32'hDEADBEEF);
        cyc(); req0 = 1'b0; we0 = 1'b0; #1;
        chk("t3_gnt_r", {gnt0, gnt1}, 2'b01);
        chk("t3_wen_r", WEN, 1'b1);
        chk("t3_no_rv_wr", rvalid0, 1'b0);
        // Both read singles: prio should be back at 0
        cyc(); req0 = 1'b1; addr0 = 10'd3; len0 = 4'd1; addr1 = 10'd4; #1;
        chk("t3_rv1", rvalid1, 1'b1);
        chk("t3_rdata1", rdata1, 32'hDEADBEEF);
        chk("t3_prio0", {gnt0, gnt1}, 2'b10);
        chk("t3_prio0_a", A, 10'd3);
        cyc(); req0 = 1'b0; #1;
        chk("t3_rr_gnt1", {gnt0, gnt1}, 2'b01);
        chk("t3_rr_a", A, 10'd4);
        chk("t3_rdata0", rdata0, pat(3));
        cyc(); req1 = 1'b0; #1;
        chk("t3_rdata1b", rdata1, pat(4));

        // Wrapping burst at 1022 with requester 0 stalled mid-burst
        cyc(); req1 = 1'b1; addr1 = 10'd1022; len1 = 4'd4; #1;
        chk("t4_a0", A, 10'd1022);
        cyc(); req0 = 1'b1; addr0 = 10'd5; len0 = 4'd1; #1;
        chk("t4_a1", A, 10'd1023);
        chk("t4_stall1", {gnt0, gnt1}, 2'b01);
        chk("t4_rdata", rdata1, pat(1022));
        cyc(); #1;
        chk("t4_a2", A, 10'd0);
        chk("t4_stall2", {gnt0, gnt1}, 2'b01);
        cyc(); #1;
        chk("t4_a3", A, 10'd1);
        chk("t4_stall3", {gnt0, gnt1}, 2'b01);
        cyc(); req1 = 1'b0; #1;
        chk("t4_gnt0", {gnt0, gnt1}, 2'b10);
        chk("t4_gnt0_a", A, 10'd5);
        chk("t4_rdata_wrap", rdata1, 32'h3fe00000);
        cyc(); req0 = 1'b0; #1;
        chk("t4_rdata0", rdata0, pat(5));

        // Aborted burst: len 6, dropped after 3 grants
        rv_cnt = 0;
        cyc(); req1 = 1'b1; addr1 = 10'd20; len1 = 4'd6; #1;
        chk("t5_a0", A, 10'd20);
        for (int k = 1; k < 3; k++) begin
            cyc(); #1;
            rv_cnt += int'(rvalid1);
            chk("t5_a", A, 10'(20 + k));
        end
        cyc(); req1 = 1'b0; #1;
        rv_cnt += int'(rvalid1);
        chk("t5_abort_cen", CEN, 1'b1);
        chk("t5_abort_gnt", gnt1, 1'b0);
        cyc(); #1;
        rv_cnt += int'(rvalid1);
        chk("t5_idle", busy, 1'b0);
        cyc(); #1;
        rv_cnt += int'(rvalid1);
        chk("t5_rv_pulses", rv_cnt, 3);

        // len=0 is a single beat
        cyc(); req1 = 1'b1; addr1 = 10'd40; len1 = 4'd0; #1;
        chk("t5_len0_gnt", gnt1, 1'b1);
        cyc(); req1 = 1'b0; #1;
        chk("t5_len0_busy", busy, 1'b0);
        chk("t5_len0_rdata", rdata1, pat(40));

        // len=12 clamps to 8 beats
        cyc(); req1 = 1'b1; addr1 = 10'd48; len1 = 4'd12; #1;
        for (int k = 1; k < 8; k++) begin
            cyc(); #1;
            chk("t5_len12_busy", busy, 1'b1);
        end
        chk("t5_len12_a", A, 10'd55);
        cyc(); req1 = 1'b0; #1;
        chk("t5_len12_end", busy, 1'b0);

        // Reset during 3rd beat of a len-8 burst
        cyc(); req1 = 1'b1; addr1 = 10'd100; len1 = 4'd8; #1;
        chk("t6_a0", A, 10'd100);
        cyc(); req0 = 1'b1; addr0 = 10'd7; len0 = 4'd1; #1;
        chk("t6_a1", A, 10'd101);
        cyc(); #1;
        chk("t6_a2", A, 10'd102);
        RSTN = 1'b0; #1;
        chk("t6_rst_cen", CEN, 1'b1);
        chk("t6_rst_wen", WEN, 1'b1);
        chk("t6_rst_gnt", {gnt0, gnt1}, 2'b00);
        chk("t6_rst_busy", busy, 1'b0);
        cyc(); #1;
        chk("t6_rst_rv", {rvalid0, rvalid1}, 2'b00);
        chk("t6_rst_cen2", CEN, 1'b1);
        cyc(); RSTN = 1'b1; #1;
        chk("t6_post_gnt", {gnt0, gnt1}, 2'b10);
        chk("t6_post_a", A, 10'd7);
        cyc(); req0 = 1'b0; req1 = 1'b0; #1;
        chk("t6_post_rv", {rvalid0, rvalid1}, 2'b10);
        chk("t6_post_rdata", rdata0, pat(7));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
